toy_cpu_sequencer: RTL and testbench
====================================

# toy_cpu_sequencer

Instruction sequencer that sits in front of `toy_cpu` and feeds it from the 8-bit pin bus.
- Assembles 3-byte instructions, buffers them in a DEPTH-entry FIFO and issues one instruction per `op_valid` pulse.
- Issue runs either free-running (`run`) or single-step (`step` rising edge).
- Optionally captures the combinational CPU result into a register.

## Interface
- `DEPTH`, default 4: instruction FIFO entries; power of two, at least 2.
- `clk  in  1`: single clock; all state updates on the rising edge.
- `rst  in  1`: asynchronous, active-low reset.
- `in_byte  in  8`: instruction byte.
- `in_valid  in  1`: `in_byte` is valid this cycle.
- `in_ready  out  1`: the sequencer accepts `in_byte` this cycle.
- `run  in  1`: level; issue continuously while the FIFO is non-empty.
- `step  in  1`: level; each 0→1 transition grants exactly one issue.
- `flush  in  1`: synchronous; discards the FIFO and any partial instruction.
- `op_valid  out  1`: one-cycle issue strobe to `toy_cpu`.
- `opcode  out  3`, `src_a  out  3`, `src_b  out  3`, `dest  out  3`, `imm  out  8`: issued instruction fields, registered.
- `cpu_out  in  8`: `toy_cpu` result bus; used only with `TOY_SEQ_CAPTURE_EN`.
- `result  out  8`: captured result.
- `result_valid  out  1`: result-capture strobe.
- `level  out  $clog2(DEPTH)+1`: FIFO occupancy.
- `busy  out  1`: high when the FIFO is non-empty, OR `op_valid` is high, OR the assembly FSM is not in state `B0`.

## Operation
- **Handshake:** a byte transfers on a rising edge where `in_valid` and `in_ready` are both 1.
- **Byte formats:**
  - Byte 0: [7:5] `opcode`, [4:2] `dest`, [1:0] ignored.
  - Byte 1: [7:5] `src_a`, [4:2] `src_b`, [1:0] ignored.
  - Byte 2: `imm`.
- **Assembly FSM:** states `B0` → `B1` → `B2` → `B0`, advancing on each transfer.
  - `in_ready` = 1 in `B0` and `B1`.
  - In `B2`, `in_ready` = 1 only if `level` < DEPTH.
  - The transfer of byte 2 pushes the assembled 20-bit instruction.
- **Issue:** a pop occurs on an edge where the FIFO is non-empty, `flush` = 0, and either `run` = 1 or a step grant is pending.
  - After a pop edge, `op_valid` = 1 for exactly one cycle, with the fields driven from the popped entry.
  - While `op_valid` = 0, the fields hold their last issued values.
- **Step grant:**
  - A rising edge on `step`, detected against a registered copy of `step`, sets a pending grant.
  - The next pop clears the grant.
  - Further `step` edges while a grant is pending do not accumulate.
  - While `run` = 1, `step` is ignored and the pending grant is cleared.
- **Opcode 000:** no-op for the CPU; issued like any other instruction.
- **Flush:** highest priority.
  - On a flush edge: `level` → 0, FSM → `B0`, pending grant cleared, no push, no pop.
  - `op_valid` is 0 in the following cycle.
  - A byte presented during the flush cycle is consumed and dropped.
- **Pointers:** `$clog2(DEPTH)` bits, wrapping modulo DEPTH.
- **Simultaneous push and pop:** legal when the FIFO is non-empty; `level` is unchanged.
- **Empty FIFO:** a push into an empty FIFO is not popped in the same edge; there is no bypass.

## Timing
- **Reset values:** `in_ready`=1, `op_valid`=0, all fields 0, `result`=0, `result_valid`=0, `level`=0, `busy`=0, FSM=`B0`, no pending grant, registered `step`=0.
- **Issue latency:** with `run`=1 and an empty FIFO, byte 2 transferred at edge N gives a pop at edge N+1 and `op_valid` high in cycle N+1..N+2.
- **Throughput:** with `run`=1, back-to-back issue is one instruction per cycle while the FIFO is non-empty.
- **Input rate:** one instruction per 3 cycles sustained.
- **Step latency:** `step` rising at edge S is detected at edge S+1 and popped at edge S+1 if the FIFO is non-empty. `op_valid` is therefore high in the cycle after edge S+1.
- **Reset mid-operation:** returns to reset values immediately, asynchronously. The partial instruction and FIFO contents are lost.

## Configuration
- **`TOY_SEQ_CAPTURE_EN` defined:**
  - On every edge ending a cycle with `op_valid`=1, `result` ← `cpu_out`.
  - `result_valid` = 1 for the following cycle only.
  - `result` holds between captures.
  - Flush does not clear `result`.
- **Not defined:**
  - `result` = 0 and `result_valid` = 0 constantly.
  - `cpu_out` is unused; the ports remain present.

## Test plan
- **Reset:** assert `rst`=0 mid-transfer → all outputs at reset values; after release, the next byte is taken as byte 0.
- **Single issue:** `run`=1, send 0xE4, 0x00, 0x5A → at edge N+1 `op_valid` pulses once with `opcode`=7, `dest`=1, `imm`=0x5A; `level` returns to 0.
- **Fill to full:** `run`=0, DEPTH=4, send 4 instructions → `level`=4, `in_ready`=0 in `B2` of a 5th instruction. Set `run`=1 → 4 consecutive `op_valid` cycles in FIFO order, then the 5th instruction is accepted.
- **Step mode:** `run`=0, 2 entries queued, hold `step` high 5 cycles → exactly one `op_valid`. Drop `step`, raise it again → the second entry issues.
- **Flush:** flush in `B1` with 2 entries queued → `level`=0, `busy`=0 the next cycle, no `op_valid`; a following 3-byte instruction issues normally.
- **Capture (macro on):** issue with `cpu_out`=0x3C during the `op_valid` cycle → `result`=0x3C and `result_valid`=1 one cycle later. With the macro off, both stay 0.

Source files
------------

// File: rtl/toy_cpu_sequencer.sv
// toy_cpu_sequencer: assembles 3-byte instructions into a FIFO and issues them to toy_cpu (run or single-step).
// Optional result capture is enabled by defining TOY_SEQ_CAPTURE_EN.
module toy_cpu_sequencer #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             i_in_byte,
  input  logic                   i_in_valid,
  output logic                   o_in_ready,
  input  logic                   i_run,
  input  logic                   i_step,
  input  logic                   i_flush,
  output logic                   o_op_valid,
  output logic [2:0]             o_opcode,
  output logic [2:0]             o_src_a,
  output logic [2:0]             o_src_b,
  output logic [2:0]             o_dest,
  output logic [7:0]             o_imm,
  input  logic [7:0]             i_cpu_out,
  output logic [7:0]             o_result,
  output logic                   o_result_valid,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_busy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
  typedef enum logic [1:0] {B0, B1, B2} state_t;
  state_t r_state, w_state_nxt;
  logic [5:0] r_hi0, r_hi1;
  logic [19:0] r_mem [DEPTH];
  logic [19:0] r_fields;
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0] r_level;
  logic r_step_q, r_grant, r_op_valid;
  logic w_xfer, w_push, w_pop, w_rise, w_grant_nxt;
  always_comb begin
    w_state_nxt = r_state;
    o_in_ready = (r_state != B2) || (r_level < FULL);
    w_xfer = i_in_valid && o_in_ready;
    w_push = w_xfer && (r_state == B2) && !i_flush;
    w_rise = i_step && !r_step_q && !i_run;
    // A fresh step edge may pop on the same edge that would otherwise set the grant
    w_pop = (r_level != '0) && !i_flush && (i_run || r_grant || w_rise);
    if (i_flush) w_state_nxt = B0;
    else if (w_xfer) w_state_nxt = (r_state == B0) ? B1 : (r_state == B1) ? B2 : B0;
    w_grant_nxt = (i_flush || i_run || w_pop) ? 1'b0 : (r_grant || w_rise);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= B0;
    else r_state <= w_state_nxt;
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {r_hi0, r_hi1, i_in_byte};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi0 <= '0;
      r_hi1 <= '0;
      r_fields <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_level <= '0;
      r_step_q <= 1'b0;
      r_grant <= 1'b0;
      r_op_valid <= 1'b0;
    end else begin
      if (w_xfer && r_state == B0) r_hi0 <= i_in_byte[7:2];
      if (w_xfer && r_state == B1) r_hi1 <= i_in_byte[7:2];
      r_step_q <= i_step;
      r_grant <= w_grant_nxt;
      r_op_valid <= w_pop;
      if (i_flush) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_level <= '0;
      end else begin
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_pop) begin
          r_rptr <= r_rptr + 1'b1;
          r_fields <= r_mem[r_rptr];
        end
        r_level <= r_level + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
      end
    end
  end
  assign o_op_valid = r_op_valid;
  assign o_opcode = r_fields[19:17];
  assign o_dest = r_fields[16:14];
  assign o_src_a = r_fields[13:11];
  assign o_src_b = r_fields[10:8];
  assign o_imm = r_fields[7:0];
  assign o_level = r_level;
  assign o_busy = (r_level != '0) || r_op_valid || (r_state != B0);
`ifdef TOY_SEQ_CAPTURE_EN
  logic [7:0] r_result;
  logic r_result_valid;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_result_valid <= 1'b0;
    end else begin
      r_result_valid <= r_op_valid;
      if (r_op_valid) r_result <= i_cpu_out;
    end
  end
  assign o_result = r_result;
  assign o_result_valid = r_result_valid;
`else
  logic w_unused_cpu_out;
  assign w_unused_cpu_out = ^i_cpu_out;
  assign o_result = '0;
  assign o_result_valid = 1'b0;
`endif
endmodule

// File: tb/tb_toy_cpu_sequencer.sv
// tb_toy_cpu_sequencer: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_toy_cpu_sequencer;
  localparam int DEPTH = 4;
`ifdef TOY_SEQ_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] in_byte = '0, cpu_out = '0;
  logic in_valid = 1'b0, run = 1'b0, step = 1'b0, flush = 1'b0;
  logic in_ready, op_valid, result_valid, busy;
  logic [2:0] opcode, src_a, src_b, dest;
  logic [7:0] imm, result;
  logic [$clog2(DEPTH):0] level;
  logic [19:0] fields;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  assign fields = {opcode, dest, src_a, src_b, imm};
  toy_cpu_sequencer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .i_in_byte(in_byte), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .i_run(run), .i_step(step), .i_flush(flush), .o_op_valid(op_valid), .o_opcode(opcode),
    .o_src_a(src_a), .o_src_b(src_b), .o_dest(dest), .o_imm(imm), .i_cpu_out(cpu_out),
    .o_result(result), .o_result_valid(result_valid), .o_level(level), .o_busy(busy)
  );
  // Reference model: instruction queue, byte counter and a pending-grant flag
  logic [19:0] mq[$];
  int m_cnt;
  logic [5:0] m_h0, m_h1;
  bit m_grant, m_stepq, m_opv, m_resv, m_xfer, m_pop, m_rise;
  logic [19:0] m_f;
  logic [7:0] m_res;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete(); m_cnt = 0; m_h0 = 0; m_h1 = 0; m_grant = 0; m_stepq = 0;
      m_opv = 0; m_f = 0; m_res = 0; m_resv = 0;
    end else begin
      m_xfer = in_valid && ((m_cnt != 2) || (mq.size() < DEPTH));
      m_rise = step && !m_stepq;
      m_pop = (mq.size() > 0) && !flush && (run || m_grant || m_rise);
      if (CAP) begin
        if (m_opv) m_res = cpu_out;
        m_resv = m_opv;
      end
      m_opv = m_pop;
      if (m_pop) m_f = mq.pop_front();
      if (flush) begin
        mq.delete(); m_cnt = 0; m_grant = 0;
      end else begin
        if (m_xfer) begin
          if (m_cnt == 0) m_h0 = in_byte[7:2];
          else if (m_cnt == 1) m_h1 = in_byte[7:2];
          else mq.push_back({m_h0, m_h1, in_byte});
          m_cnt = (m_cnt + 1) % 3;
        end
        if (run || m_pop) m_grant = 0;
        else if (m_rise) m_grant = 1;
      end
      m_stepq = step;
    end
  end
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_byte = b;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (!in_ready) begin errors++; $display("FAIL send_byte timeout: in_ready=%b, required 1", in_ready); end
    tick();
    in_valid = 1'b0;
  endtask
  task automatic send_instr(output logic [19:0] exp);
    logic [7:0] b0, b1, b2;
    b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
    exp = {b0[7:2], b1[7:2], b2};
    send_byte(b0); send_byte(b1); send_byte(b2);
  endtask
  task automatic clean();
    run = 1'b0; step = 1'b0; in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
  endtask
  task automatic test_reset();
    repeat (2) tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b, want 1", in_ready); end
    checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL reset op_valid: got %b, want 0", op_valid); end
    checks++; if (fields !== 20'h0) begin errors++; $display("FAIL reset fields: got %h, want 0", fields); end
    checks++; if (level !== '0 || busy !== 1'b0) begin errors++; $display("FAIL reset level/busy: got %0d/%b, want 0/0", level, busy); end
    checks++; if (result !== 8'h0 || result_valid !== 1'b0) begin errors++; $display("FAIL reset result: got %h/%b, want 00/0", result, result_valid); end
    rst_n = 1'b1;
    run = 1'b1;
    in_byte = 8'hFF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset mid busy: got %b, want 1", busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || in_ready !== 1'b1 || level !== '0) begin errors++; $display("FAIL reset async: busy=%b in_ready=%b level=%0d, want 0/1/0", busy, in_ready, level); end
    tick();
    rst_n = 1'b1;
    send_byte(8'h44); send_byte(8'h00); send_byte(8'h11);
    tick();
    checks++; if (op_valid !== 1'b1 || opcode !== 3'd2 || dest !== 3'd1 || imm !== 8'h11) begin errors++; $display("FAIL reset realign: op_valid=%b opcode=%0d dest=%0d imm=%h, want 1/2/1/11", op_valid, opcode, dest, imm); end
    run = 1'b0;
    tick();
  endtask
  task automatic test_single_issue();
    clean();
    run = 1'b1;
    send_byte(8'hE4); send_byte(8'h00); send_byte(8'h5A);
    checks++; if (level !== 1 || op_valid !== 1'b0) begin errors++; $display("FAIL single pre-issue: level=%0d op_valid=%b, want 1/0", level, op_valid); end
    tick();
    checks++; if (op_valid !== 1'b1 || opcode !== 3'd7 || dest !== 3'd1 || src_a !== 3'd0 || src_b !== 3'd0 || imm !== 8'h5A) begin errors++; $display("FAIL single issue: op_valid=%b fields=%h, want 1/e405a", op_valid, fields); end
    checks++; if (level !== 0) begin errors++; $display("FAIL single level: got %0d, want 0", level); end
    tick();
    checks++; if (op_valid !== 1'b0 || imm !== 8'h5A || busy !== 1'b0) begin errors++; $display("FAIL single hold: op_valid=%b imm=%h busy=%b, want 0/5a/0", op_valid, imm, busy); end
    run = 1'b0;
  endtask
  task automatic test_fill();
    logic [19:0] exp [5];
    logic [7:0] b0, b1, b2;
    clean();
    for (int i = 0; i < 4; i++) send_instr(exp[i]);
    checks++; if (level !== 4 || in_ready !== 1'b1) begin errors++; $display("FAIL fill level: level=%0d in_ready=%b, want 4/1", level, in_ready); end
    b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
    exp[4] = {b0[7:2], b1[7:2], b2};
    send_byte(b0); send_byte(b1);
    checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL fill B2 full: in_ready=%b busy=%b, want 0/1", in_ready, busy); end
    in_byte = b2; in_valid = 1'b1; run = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (op_valid !== 1'b1 || fields !== exp[k]) begin errors++; $display("FAIL fill drain %0d: op_valid=%b fields=%h, want 1/%h", k, op_valid, fields, exp[k]); end
      if (k == 1) begin
        in_valid = 1'b0;
        checks++; if (level !== 3) begin errors++; $display("FAIL fill push+pop level: got %0d, want 3", level); end
      end
    end
    tick();
    checks++; if (op_valid !== 1'b0 || level !== 0) begin errors++; $display("FAIL fill end: op_valid=%b level=%0d, want 0/0", op_valid, level); end
    run = 1'b0;
  endtask
  task automatic test_step();
    logic [19:0] e0, e1;
    int cnt;
    clean();
    send_instr(e0); send_instr(e1);
    checks++; if (level !== 2 || op_valid !== 1'b0) begin errors++; $display("FAIL step queued: level=%0d op_valid=%b, want 2/0", level, op_valid); end
    step = 1'b1;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (op_valid) cnt++;
      if (k == 0) begin
        checks++; if (op_valid !== 1'b1 || fields !== e0) begin errors++; $display("FAIL step latency: op_valid=%b fields=%h, want 1/%h", op_valid, fields, e0); end
      end
    end
    checks++; if (cnt != 1 || level !== 1) begin errors++; $display("FAIL step held: issues=%0d level=%0d, want 1/1", cnt, level); end
    step = 1'b0;
    tick();
    step = 1'b1;
    tick();
    checks++; if (op_valid !== 1'b1 || fields !== e1 || level !== 0) begin errors++; $display("FAIL step second: op_valid=%b fields=%h level=%0d, want 1/%h/0", op_valid, fields, level, e1); end
    step = 1'b0;
    tick();
    checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL step after: op_valid=%b, want 0", op_valid); end
  endtask
  task automatic test_flush();
    logic [19:0] e0, e1;
    clean();
    send_instr(e0); send_instr(e1);
    send_byte(8'h3C);
    flush = 1'b1; in_byte = 8'hFF; in_valid = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (level !== 0 || busy !== 1'b0 || op_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush state: level=%0d busy=%b op_valid=%b in_ready=%b, want 0/0/0/1", level, busy, op_valid, in_ready); end
    run = 1'b1;
    tick();
    checks++; if (op_valid !== 1'b0) begin errors++; $display("FAIL flush no issue: op_valid=%b, want 0", op_valid); end
    send_instr(e0);
    tick();
    checks++; if (op_valid !== 1'b1 || fields !== e0) begin errors++; $display("FAIL flush next instr: op_valid=%b fields=%h, want 1/%h", op_valid, fields, e0); end
    run = 1'b0;
    tick();
  endtask
  task automatic test_capture();
    logic [19:0] e0;
    clean();
    run = 1'b1;
    send_instr(e0);
    tick();
    checks++; if (op_valid !== 1'b1) begin errors++; $display("FAIL capture issue: op_valid=%b, want 1", op_valid); end
    cpu_out = 8'h3C;
    tick();
    checks++; if (result !== (CAP ? 8'h3C : 8'h00) || result_valid !== CAP) begin errors++; $display("FAIL capture: result=%h valid=%b, want %h/%b", result, result_valid, CAP ? 8'h3C : 8'h00, CAP); end
    cpu_out = 8'hA5;
    tick();
    checks++; if (result !== (CAP ? 8'h3C : 8'h00) || result_valid !== 1'b0) begin errors++; $display("FAIL capture hold: result=%h valid=%b, want %h/0", result, result_valid, CAP ? 8'h3C : 8'h00); end
    run = 1'b0;
  endtask
  task automatic test_random();
    logic exp_rdy, exp_busy;
    clean();
    for (int c = 0; c < 1500; c++) begin
      exp_rdy = (m_cnt != 2) || (mq.size() < DEPTH);
      exp_busy = (mq.size() > 0) || m_opv || (m_cnt != 0);
      checks++; if (in_ready !== exp_rdy) begin errors++; $display("FAIL rnd in_ready @%0d: got %b, want %b", c, in_ready, exp_rdy); end
      checks++; if (op_valid !== m_opv) begin errors++; $display("FAIL rnd op_valid @%0d: got %b, want %b", c, op_valid, m_opv); end
      checks++; if (fields !== m_f) begin errors++; $display("FAIL rnd fields @%0d: got %h, want %h", c, fields, m_f); end
      checks++; if (level !== ($clog2(DEPTH)+1)'(mq.size())) begin errors++; $display("FAIL rnd level @%0d: got %0d, want %0d", c, level, mq.size()); end
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL rnd busy @%0d: got %b, want %b", c, busy, exp_busy); end
      checks++; if (result !== m_res || result_valid !== m_resv) begin errors++; $display("FAIL rnd result @%0d: got %h/%b, want %h/%b", c, result, result_valid, m_res, m_resv); end
      in_valid = ($urandom_range(0, 3) != 0);
      in_byte = 8'($urandom);
      cpu_out = 8'($urandom);
      if ($urandom_range(0, 40) == 0) run = ~run;
      if ($urandom_range(0, 2) == 0) step = ~step;
      flush = ($urandom_range(0, 60) == 0);
      tick();
    end
    in_valid = 1'b0; run = 1'b0; step = 1'b0; flush = 1'b0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    test_reset();
    test_single_issue();
    test_fill();
    test_step();
    test_flush();
    test_capture();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
